accel_trap_integrator: RTL
==========================

# accel_trap_integrator

Multi-channel trapezoidal integrator for accelerometer samples, exposed as a multi-cycle custom-instruction slave on the processor bus. Per call it computes new_sum = old_sum + dt·(a_now + a_prev)/2 for one selected channel. Samples are signed fixed-point. Each channel keeps its own previous sample. The first sample after clear only primes a channel. Results saturate instead of wrapping. It generalises the single-channel integrator to N axes with parametrised width and time step, plus priming, clear and read-back operations.

## Interface
- DATA_W, 32, sample and sum width, signed two's complement
- CHANNELS, 3, number of independent channels (1..16)
- DT_MULT, 1, unsigned time-step multiplier, DT_W bits
- DT_W, 16, width of DT_MULT
- DT_SHIFT, 0, right-shift applied after the multiply; dt = DT_MULT / 2^DT_SHIFT
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- clk_en  in  1  qualifies every state change; when low the block holds state
- start  in  1  one-cycle request, sampled only in IDLE with clk_en high
- n  in  8  n[7:6] = op, n[3:0] = channel index
- dataA  in  DATA_W  new accelerometer sample (signed)
- dataB  in  DATA_W  old sum (signed)
- done  out  1  one-cycle pulse, result valid in the same cycle
- result  out  DATA_W  new sum or read-back value
- overflow  out  1  sticky saturation flag

## Operation
- Ops selected by n[7:6]:
  - 00 INTEGRATE, with channel ch = n[3:0]:
    - If valid[ch]=0: result=dataB (prime only).
    - Otherwise: result = sat(dataB + inc).
    - In both cases: prev[ch]←dataA, valid[ch]←1.
  - 01 CLEAR: valid[ch]←0 and prev[ch]←0; result=0.
  - 10 READ_PREV: result=prev[ch]; no state change.
  - 11 CLEAR_ALL: all valid←0, all prev←0, overflow←0; result=0.
- Channel index ≥ CHANNELS: no state change, result=0, done still pulses.
- Arithmetic:
  - s = dataA + prev, sign-extended to DATA_W+1 bits.
  - p = s · DT_MULT, signed × unsigned, DATA_W+DT_W+1 bits.
  - inc = p >>> (DT_SHIFT+1), arithmetic shift, so it floors toward −∞.
  - The sum dataB + inc is formed at full width, then clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Any clamp sets overflow; overflow clears only on reset or CLEAR_ALL.
- FSM states IDLE → CALC → ACC → DONE → IDLE:
  - IDLE: on start latch n, dataA, dataB.
  - CALC: register p.
  - ACC: register the saturated sum and update channel state.
  - DONE: pulse done.
- Every transition requires clk_en=1.

## Timing
- Reset values: done=0, result=0, overflow=0, FSM=IDLE, all valid=0, all prev=0.
- Latency: start accepted at edge 0; done=1 in the cycle after edge 3, assuming clk_en is high throughout.
- Each clk_en-low cycle adds one cycle of stall; done stays high until the next enabled edge.
- result holds its value after done until the next op completes.
- Throughput: one op per 4 enabled cycles; back-to-back start is accepted in the cycle done is high.
- start while not IDLE is ignored; no queueing.
- dataA, dataB and n are captured at acceptance; later changes have no effect.
- Reset asserted mid-op: the op is aborted, done is never pulsed, and channel state is cleared.

## Structure
- Package accel_int_pkg holds:
  - op encodings OP_INTEGRATE, OP_CLEAR, OP_READ_PREV, OP_CLEAR_ALL
  - the FSM state typedef
  - the CH_IDX_W constant
- One sub-module, sat_add, computes the signed wide add plus clamp and the overflow indication. It is combinational and parametrised by input and output width.
- Channel state (prev array, valid vector) lives in the top as registers, not RAM, so reset can clear it.

## Test plan
All scenarios use DATA_W=32, CHANNELS=3, DT_MULT=1, DT_SHIFT=0, so inc = floor((a+prev)/2).
- Prime then integrate:
  - INTEGRATE ch0, A=100, B=0 → result=0, done 4 cycles after start.
  - Then A=200, B=0 → result=150.
- Negative floor: ch1 primed with −3; INTEGRATE A=0, B=10 → result=8 (inc=−2).
- Saturation: ch2 prev=100; INTEGRATE A=100, B=0x7FFFFFF0 → result=0x7FFFFFFF, overflow=1.
  - A following in-range op leaves overflow=1; CLEAR_ALL clears it.
- Channel isolation:
  - Interleave ch0 and ch1 integrates; READ_PREV returns each channel's own last sample.
  - CLEAR ch0 leaves ch1 unchanged; the next ch0 integrate only primes.
- Stall and ignore:
  - Drop clk_en for 5 cycles mid-op → done arrives 5 cycles late, value unchanged.
  - Pulse start during CALC → no extra done.
- Reset mid-op: assert reset in ACC → done stays 0; after release, READ_PREV ch0 returns 0 and the next integrate only primes.

Source files
------------

// File: rtl/accel_trap_integrator_pkg.sv
// Shared types and constants for the multi-channel trapezoidal integrator.
// Holds op encodings, FSM state type and channel index width.
package accel_int_pkg;

  localparam int CH_IDX_W = 4;

  typedef enum logic [1:0] {
    OP_INTEGRATE = 2'b00,
    OP_CLEAR     = 2'b01,
    OP_READ_PREV = 2'b10,
    OP_CLEAR_ALL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_ACC  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/accel_trap_integrator_sat_add.sv
// Signed add of two IN_W operands at full width, clamped to a signed OUT_W range.
// sat flags that the clamp was applied.
module sat_add #(
  parameter int IN_W  = 49,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = {a[IN_W-1], a} + {b[IN_W-1], b};
    y   = sum[OUT_W-1:0];
    sat = 1'b0;
    if (sum > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (sum < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/accel_trap_integrator.sv
// Multi-channel trapezoidal integrator custom-instruction slave:
// new_sum = old_sum + dt*(a_now + a_prev)/2, saturating, with per-channel priming.
module accel_trap_integrator
  import accel_int_pkg::*;
#(
  parameter int             DATA_W   = 32,
  parameter int             CHANNELS = 3,
  parameter int             DT_W     = 16,
  parameter logic [DT_W-1:0] DT_MULT = 1,
  parameter int             DT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [7:0]        n,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int S_W = DATA_W + 1;
  localparam int P_W = DATA_W + DT_W + 1;

  state_e state_reg, state_next;
  logic   latch_en, calc_en, acc_en, done_set;

  op_e                        op_reg;
  logic [CH_IDX_W-1:0]        ch_reg;
  logic signed [DATA_W-1:0]   a_reg, b_reg;
  logic signed [P_W-1:0]      p_reg;
  logic signed [DATA_W-1:0]   sum_reg, result_reg;
  logic                       done_reg, overflow_reg;

  logic signed [DATA_W-1:0]   prev_vec [CHANNELS];
  logic [CHANNELS-1:0]        valid_vec;

  logic                       ch_ok, valid_sel;
  logic signed [DATA_W-1:0]   prev_sel;
  logic signed [S_W-1:0]      s_sum;
  logic signed [P_W-1:0]      p_next, inc, b_ext, dt_ext;
  logic signed [DATA_W-1:0]   sat_sum, acc_result;
  logic                       sat_hit, ovf_set, ch_write, ch_clear, clear_all;
  logic                       unused_n_bits;

  assign unused_n_bits = ^n[5:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clk_en) begin
      case (state_reg)
        ST_IDLE: if (start) state_next = ST_CALC;
        ST_CALC: state_next = ST_ACC;
        ST_ACC:  state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    latch_en = clk_en && (state_reg == ST_IDLE) && start;
    calc_en  = clk_en && (state_reg == ST_CALC);
    acc_en   = clk_en && (state_reg == ST_ACC);
    done_set = clk_en && (state_reg == ST_DONE);
  end

  // Widened compare so CHANNELS=16 does not wrap to zero.
  assign ch_ok = {1'b0, ch_reg} < (CH_IDX_W + 1)'(CHANNELS);

  always_comb begin
    prev_sel  = '0;
    valid_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_reg == CH_IDX_W'(i)) begin
        prev_sel  = prev_vec[i];
        valid_sel = valid_vec[i];
      end
    end
  end

  always_comb begin
    s_sum  = {a_reg[DATA_W-1], a_reg} + {prev_sel[DATA_W-1], prev_sel};
    dt_ext = $signed({{(P_W-DT_W){1'b0}}, DT_MULT});
    p_next = P_W'(s_sum) * dt_ext;
    inc    = p_reg >>> (DT_SHIFT + 1);
    b_ext  = P_W'(b_reg);
  end

  sat_add #(
    .IN_W  (P_W),
    .OUT_W (DATA_W)
  ) u_sat_add (
    .a   (b_ext),
    .b   (inc),
    .y   (sat_sum),
    .sat (sat_hit)
  );

  always_comb begin
    acc_result = '0;
    ovf_set    = 1'b0;
    ch_write   = 1'b0;
    ch_clear   = 1'b0;
    clear_all  = 1'b0;
    if (op_reg == OP_CLEAR_ALL) begin
      clear_all = 1'b1;
    end else if (ch_ok) begin
      case (op_reg)
        OP_INTEGRATE: begin
          ch_write   = 1'b1;
          acc_result = valid_sel ? sat_sum : b_reg;
          ovf_set    = valid_sel && sat_hit;
        end
        OP_CLEAR:     ch_clear   = 1'b1;
        OP_READ_PREV: acc_result = prev_sel;
        default:      acc_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg       <= OP_INTEGRATE;
      ch_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      p_reg        <= '0;
      sum_reg      <= '0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (latch_en) begin
        op_reg <= op_e'(n[7:6]);
        ch_reg <= n[3:0];
        a_reg  <= dataA;
        b_reg  <= dataB;
      end
      if (calc_en) p_reg <= p_next;
      if (acc_en) begin
        sum_reg <= acc_result;
        if (clear_all)    overflow_reg <= 1'b0;
        else if (ovf_set) overflow_reg <= 1'b1;
      end
      if (done_set) result_reg <= sum_reg;
      if (clk_en)   done_reg   <= done_set;
    end
  end

  // Channel state stays in flops so reset and CLEAR_ALL can wipe it in one edge.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [DATA_W-1:0] ch_prev_reg;
    logic                     ch_valid_reg;
    logic                     ch_hit;

    assign ch_hit = (ch_reg == CH_IDX_W'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ch_prev_reg  <= '0;
        ch_valid_reg <= 1'b0;
      end else if (acc_en) begin
        if (clear_all || (ch_clear && ch_hit)) begin
          ch_prev_reg  <= '0;
          ch_valid_reg <= 1'b0;
        end else if (ch_write && ch_hit) begin
          ch_prev_reg  <= a_reg;
          ch_valid_reg <= 1'b1;
        end
      end
    end

    assign prev_vec[gi]  = ch_prev_reg;
    assign valid_vec[gi] = ch_valid_reg;
  end

  assign done     = done_reg;
  assign result   = result_reg;
  assign overflow = overflow_reg;

endmodule
